program_loader: RTL and testbench

//   Streams a program into the pipeline instruction memory, then resets and runs the pipeline.

---
 rtl/program_loader_if.sv | 11 +
 rtl/program_loader.sv | 217 +++++++++++++++++++++
 tb/tb_program_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Host byte link between the host and program_loader: one byte per valid&ready handshake.
interface program_loader_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, resets the pipeline and supervises its run.
// Optional writeback trace FIFO enabled by defining PROGRAM_LOADER_TRACE_EN.
module program_loader #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_BYTE      = 8,
  parameter int MAX_INSTR    = 256,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 4096,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         i_rst,
  program_loader_if.slave              rx,
  input  logic                         i_reload,
  output logic                         o_we_IF,
  output logic [NB_DATA-1:0]           o_instruction_data,
  output logic [31:0]                  o_inst_addr,
  output logic                         o_halt,
  output logic                         o_pipe_rst_n,
  input  logic                         i_end_of_prog,
  input  logic                         i_wb_enable,
  input  logic [NB_ADDR-1:0]           i_wb_reg,
  input  logic [NB_DATA-1:0]           i_wb_data,
  input  logic                         i_trace_pop,
  output logic                         o_trace_valid,
  output logic [NB_ADDR+NB_DATA-1:0]   o_trace_data,
  output logic                         o_trace_overflow,
  output logic [$clog2(MAX_INSTR):0]   o_instr_count,
  output logic [31:0]                  o_cycle_count,
  output logic                         o_done,
  output logic                         o_timeout
);

  localparam int CW    = $clog2(MAX_INSTR) + 1;
  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int PRE_W = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {S_LOAD, S_WRITE, S_PRESET, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_DATA-1:0] word_nxt;
  logic [CW-1:0]      count_q, count_d;
  logic [31:0]        addr_q, addr_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [31:0]        cyc_q, cyc_d;
  logic               timeout_q, timeout_d;
  logic               fifo_clr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign word_nxt = {shift_q[NB_DATA-NB_BYTE-1:0], rx.rx_data};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    count_d      = count_q;
    addr_d       = addr_q;
    pre_d        = pre_q;
    cyc_d        = cyc_q;
    timeout_d    = timeout_q;
    fifo_clr     = 1'b0;
    rx.rx_ready  = 1'b0;
    o_we_IF      = 1'b0;
    o_halt       = 1'b1;
    o_pipe_rst_n = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      S_LOAD: begin
        rx.rx_ready = 1'b1;
        if (rx.rx_valid) begin
          shift_d = word_nxt;
          if (idx_q == IDX_W'(BPW - 1)) begin
            idx_d   = '0;
            data_d  = word_nxt;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_WRITE: begin
        o_we_IF = 1'b1;
        count_d = count_q + CW'(1);
        addr_d  = addr_q + 32'd4;
        // A HALT opcode or a full memory ends loading; nothing is appended on the full exit.
        if (data_q[NB_DATA-1 -: 6] == 6'b111111 || count_q == CW'(MAX_INSTR - 1)) begin
          state_d = S_PRESET;
          pre_d   = '0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_PRESET: begin
        if (pre_q == PRE_W'(RESET_CYCLES - 1)) state_d = S_RUN;
        else                                   pre_d   = pre_q + PRE_W'(1);
      end
      S_RUN: begin
        o_halt       = 1'b0;
        o_pipe_rst_n = 1'b1;
        cyc_d        = sat_inc(cyc_q);
        if (i_end_of_prog) begin
          state_d = S_DONE;
        end else if (cyc_q == 32'(MAX_CYCLES - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        o_pipe_rst_n = 1'b1;
        o_done       = 1'b1;
        if (i_reload) begin
          state_d   = S_LOAD;
          count_d   = '0;
          addr_d    = '0;
          cyc_d     = '0;
          timeout_d = 1'b0;
          fifo_clr  = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      data_q    <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      pre_q     <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      pre_q     <= pre_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign o_instruction_data = data_q;
  assign o_inst_addr        = addr_q;
  assign o_instr_count      = count_q;
  assign o_cycle_count      = cyc_q;
  assign o_timeout          = timeout_q;

`ifdef PROGRAM_LOADER_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);

  logic [NB_ADDR+NB_DATA-1:0] mem_q [TRACE_DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, push_req, push, pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    pop      = i_trace_pop && !empty;
    push_req = (state_q == S_RUN) && i_wb_enable && (i_wb_reg != '0);
    push     = push_req && (!full || pop);
    wr_d     = wr_q + {{PW{1'b0}}, push};
    rd_d     = rd_q + {{PW{1'b0}}, pop};
    ovf_d    = ovf_q || (push_req && !push);
    if (fifo_clr) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= {i_wb_reg, i_wb_data};
  end

  assign o_trace_valid    = !empty;
  assign o_trace_data     = mem_q[rd_q[PW-1:0]];
  assign o_trace_overflow = ovf_q;
`else
  logic unused_trace;
  assign unused_trace     = ^{i_trace_pop, i_wb_enable, i_wb_reg, i_wb_data, fifo_clr};
  assign o_trace_valid    = 1'b0;
  assign o_trace_data     = '0;
  assign o_trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with a queue-based reference model of loading, run supervision and trace.
module tb_program_loader;
  localparam int NB_DATA = 32, NB_ADDR = 5, NB_BYTE = 8;
  localparam int MAX_INSTR = 4, RESET_CYCLES = 4, MAX_CYCLES = 40, TRACE_DEPTH = 16;
`ifdef PROGRAM_LOADER_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_rst, i_reload, i_end_of_prog, i_wb_enable, i_trace_pop;
  logic [NB_ADDR-1:0] i_wb_reg;
  logic [NB_DATA-1:0] i_wb_data;
  logic o_we_IF, o_halt, o_pipe_rst_n, o_trace_valid, o_trace_overflow, o_done, o_timeout;
  logic [NB_DATA-1:0] o_instruction_data;
  logic [31:0] o_inst_addr, o_cycle_count;
  logic [NB_ADDR+NB_DATA-1:0] o_trace_data;
  logic [$clog2(MAX_INSTR):0] o_instr_count;

  always #5 clk = ~clk;

  program_loader_if #(.NB_BYTE(NB_BYTE)) rx_if ();

  program_loader #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE), .MAX_INSTR(MAX_INSTR),
    .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk(clk), .i_rst(i_rst), .rx(rx_if), .i_reload(i_reload),
    .o_we_IF(o_we_IF), .o_instruction_data(o_instruction_data), .o_inst_addr(o_inst_addr),
    .o_halt(o_halt), .o_pipe_rst_n(o_pipe_rst_n), .i_end_of_prog(i_end_of_prog),
    .i_wb_enable(i_wb_enable), .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data),
    .i_trace_pop(i_trace_pop), .o_trace_valid(o_trace_valid), .o_trace_data(o_trace_data),
    .o_trace_overflow(o_trace_overflow), .o_instr_count(o_instr_count),
    .o_cycle_count(o_cycle_count), .o_done(o_done), .o_timeout(o_timeout)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_wr[$];
  int wr_idx;
  logic [NB_ADDR+NB_DATA-1:0] trace_q[$];
  bit ovf_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and inspect any instruction-memory write against the expected list.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_we_IF === 1'b1) begin
      check("write_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        check("wr_addr", o_inst_addr, 32'(4 * wr_idx));
        check("wr_data", o_instruction_data, exp_wr.pop_front());
        wr_idx++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int guard;
    if ($urandom_range(0, 3) == 0) begin
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'($urandom);
      step();
    end
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
    guard = 0;
    do begin
      acc = rx_if.rx_ready;
      step();
      guard++;
    end while (!acc && guard < 20);
    check("byte_accept", acc, 1);
    rx_if.rx_valid = 1'b0;
  endtask

  // Load words; the model decides how many are written (through first HALT, capped at MAX_INSTR).
  task automatic load_program(input logic [31:0] words[$]);
    int n;
    n = 0;
    for (int i = 0; i < words.size() && n < MAX_INSTR; i++) begin
      n++;
      if (words[i][31:26] == 6'b111111) break;
    end
    wr_idx = 0;
    for (int i = 0; i < n; i++) exp_wr.push_back(words[i]);
    i_reload = 1'b1;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) send_byte(words[i][31 - 8*b -: 8]);
    check("all_words_written", exp_wr.size(), 0);
    for (int c = 0; c < RESET_CYCLES; c++) begin
      i_wb_enable = 1'b1;
      i_wb_reg = 5'($urandom_range(1, 31));
      i_wb_data = $urandom;
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data = 8'($urandom);
      step();
      check("preset_rst_n", o_pipe_rst_n, 0);
      check("preset_halt", o_halt, 1);
      check("preset_ready", rx_if.rx_ready, 0);
      check("preset_trace_valid", o_trace_valid, trace_q.size() != 0);
    end
    step();
    rx_if.rx_valid = 1'b0;
    i_reload = 1'b0;
    i_wb_enable = 1'b0;
    check("instr_count", o_instr_count, n);
    check("run_rst_n", o_pipe_rst_n, 1);
    check("run_halt", o_halt, 0);
    check("run_cyc0", o_cycle_count, 0);
  endtask

  task automatic run_cycle(input bit in_run, input logic en, input logic [4:0] rg,
                           input logic [31:0] dt, input logic pop, input logic eop);
    i_wb_enable = en;
    i_wb_reg = rg;
    i_wb_data = dt;
    i_trace_pop = pop;
    i_end_of_prog = eop;
    step();
    if (pop && trace_q.size() > 0) void'(trace_q.pop_front());
    if (TRACE_EN && in_run && en && rg != 0) begin
      if (trace_q.size() < TRACE_DEPTH) trace_q.push_back({rg, dt});
      else ovf_m = 1'b1;
    end
    check("trace_valid", o_trace_valid, trace_q.size() != 0);
    if (trace_q.size() != 0) check("trace_data", o_trace_data, trace_q[0]);
    check("trace_ovf", o_trace_overflow, ovf_m);
  endtask

  // mode 0: random traffic, 1: continuous pushes with one pop at c==20, 2: R1=15 then R0.
  task automatic run_phase(input int k, input int mode);
    int c, guard;
    bit fin, eop;
    logic en, pop;
    logic [4:0] rg;
    logic [31:0] dt;
    fin = 0;
    eop = 0;
    c = 0;
    while (!fin) begin
      eop = (k > 0 && c == k - 1);
      case (mode)
        1: begin en = 1'b1; rg = 5'($urandom_range(1, 31)); dt = $urandom; pop = (c == 20); end
        2: begin en = 1'b1; rg = (c == 0) ? 5'd1 : 5'd0; dt = (c == 0) ? 32'h0F : $urandom; pop = 1'b0; end
        default: begin
          en = 1'($urandom);
          rg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          dt = $urandom;
          pop = ($urandom_range(0, 3) == 0);
        end
      endcase
      i_reload = (mode == 0) ? 1'($urandom) : 1'b0;
      run_cycle(1'b1, en, rg, dt, pop, eop);
      c++;
      fin = eop || (c == MAX_CYCLES);
      check("cycle_count", o_cycle_count, c);
      check("done", o_done, fin);
      if (!fin) check("halt_in_run", o_halt, 0);
    end
    check("timeout", o_timeout, !eop);
    check("halt_done", o_halt, 1);
    i_reload = 1'b0;
    i_end_of_prog = 1'b0;
    guard = 0;
    while (trace_q.size() > 0 && guard < 2 * TRACE_DEPTH) begin
      run_cycle(1'b0, 1'($urandom), 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0);
      guard++;
    end
    run_cycle(1'b0, 1'b1, 5'd3, 32'h55, 1'b1, 1'b0);
    check("drained_empty", o_trace_valid, 0);
    check("cycles_frozen", o_cycle_count, c);
    check("done_held", o_done, 1);
  endtask

  task automatic do_reload();
    i_reload = 1'b1;
    step();
    i_reload = 1'b0;
    trace_q.delete();
    ovf_m = 1'b0;
    check("rl_done", o_done, 0);
    check("rl_timeout", o_timeout, 0);
    check("rl_icount", o_instr_count, 0);
    check("rl_ccount", o_cycle_count, 0);
    check("rl_addr", o_inst_addr, 0);
    check("rl_ready", rx_if.rx_ready, 1);
    check("rl_tvalid", o_trace_valid, 0);
    check("rl_ovf", o_trace_overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] w;
    int nw;
    i_rst = 1'b1; i_reload = 1'b0; i_end_of_prog = 1'b0; i_wb_enable = 1'b0;
    i_wb_reg = '0; i_wb_data = '0; i_trace_pop = 1'b0;
    rx_if.rx_valid = 1'b0; rx_if.rx_data = '0;
    ovf_m = 1'b0; wr_idx = 0;
    step(); step();
    i_rst = 1'b0;
    check("rst_ready", rx_if.rx_ready, 1);
    check("rst_we", o_we_IF, 0);
    check("rst_data", o_instruction_data, 0);
    check("rst_addr", o_inst_addr, 0);
    check("rst_halt", o_halt, 1);
    check("rst_pipe_rst_n", o_pipe_rst_n, 0);
    check("rst_icount", o_instr_count, 0);
    check("rst_ccount", o_cycle_count, 0);
    check("rst_done", o_done, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_tvalid", o_trace_valid, 0);
    check("rst_ovf", o_trace_overflow, 0);

    // Partial word then reset: the two bytes must be forgotten.
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("midrst_ready", rx_if.rx_ready, 1);
    check("midrst_addr", o_inst_addr, 0);
    check("midrst_icount", o_instr_count, 0);

    prog = '{32'h2001000F, 32'hFC000000};
    load_program(prog);
    run_phase(2, 2);
    do_reload();

    // No HALT, MAX_INSTR words: runs into the cycle limit with the FIFO overfilled.
    prog.delete();
    for (int i = 0; i < MAX_INSTR; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      prog.push_back(w);
    end
    load_program(prog);
    run_phase(0, 1);
    do_reload();

    prog.delete();
    nw = $urandom_range(0, 2);
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      w[31] = 1'b0;
      prog.push_back(w);
    end
    w = $urandom;
    w[31:26] = 6'b111111;
    prog.push_back(w);
    load_program(prog);
    run_phase($urandom_range(1, 15), 0);
    do_reload();

    // End-of-program on the very cycle the limit is reached: not a timeout.
    prog.delete();
    w = $urandom;
    w[31:26] = 6'b111111;
    prog.push_back(w);
    load_program(prog);
    run_phase(MAX_CYCLES, 0);
    do_reload();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
